// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, default link parameters, receive FSM states
// and the decoded-word record passed between decoder and pipeline.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  localparam int CTRL_RUN_DEF   = 8;
  localparam int SEARCH_WIN_DEF = 2048;
  localparam int SLIP_WAIT_DEF  = 16;
  localparam int LOSS_WIN_DEF   = 4096;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } tmds_state_e;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic [7:0] data;
  } tmds_word_t;

endpackage

// File: rtl/tmds_decode_10b8b.sv
// Combinational TMDS 10b->8b decode with control-token recognition.
module tmds_decode_10b8b
  import tmds_pkg::*;
(
  input  logic [9:0] raw_i,
  output tmds_word_t word_o
);

  logic [7:0] d;

  always_comb begin
    word_o = '0;
    d      = raw_i[9] ? ~raw_i[7:0] : raw_i[7:0];
    word_o.data[0] = d[0];
    // bit 8 selects XOR vs XNOR chaining used by the encoder
    for (int i = 1; i < 8; i++) begin
      word_o.data[i] = raw_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    word_o.is_ctrl = 1'b1;
    unique case (raw_i)
      TOK_C00: word_o.ctrl = 2'b00;
      TOK_C01: word_o.ctrl = 2'b01;
      TOK_C10: word_o.ctrl = 2'b10;
      TOK_C11: word_o.ctrl = 2'b11;
      default: word_o.is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// Single-channel TMDS receiver: word alignment by control-token hunting with
// bitslip requests, then 2-stage 10b->8b decode of the aligned stream.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN   = CTRL_RUN_DEF,
  parameter int SEARCH_WIN = SEARCH_WIN_DEF,
  parameter int SLIP_WAIT  = SLIP_WAIT_DEF,
  parameter int LOSS_WIN   = LOSS_WIN_DEF
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_raw,
  output logic       O_bitslip,
  output logic       O_locked,
  output logic       O_de,
  output logic [1:0] O_ctrl,
  output logic [7:0] O_data,
  output logic       O_err
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WIN + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_WIN + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(SEARCH_WIN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WIN - 1);

  tmds_word_t dec_w, s1_q;
  tmds_state_e state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d, run_inc;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              hit;
  logic              bitslip_q, err_q, de_q;
  logic [1:0]        ctrl_q;
  logic [7:0]        data_q;

  tmds_decode_10b8b u_dec (
    .raw_i  (I_raw),
    .word_o (dec_w)
  );

  // Run counter looks at stage 1 so lock lands on the same edge that
  // the completing token reaches the outputs.
  always_comb begin
    run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    run_d   = s1_q.is_ctrl ? run_inc : '0;
    hit     = (run_d == RUN_MAX);
    state_d = state_q;
    win_d   = '0;
    wait_d  = '0;
    loss_d  = '0;
    unique case (state_q)
      SEARCH: begin
        if (hit)                  state_d = LOCKED;
        else if (win_q == WIN_MAX) state_d = SLIP;
        else                      win_d   = win_q + 1'b1;
      end
      // the pulse cycle is the first of the SLIP_WAIT settle cycles
      SLIP: begin
        run_d = '0;
        if (wait_q == WAIT_LAST) state_d = SEARCH;
        else                     wait_d  = wait_q + 1'b1;
      end
      LOCKED: begin
        if (hit)                     loss_d  = '0;
        else if (loss_q == LOSS_LAST) state_d = SEARCH;
        else                         loss_d  = loss_q + 1'b1;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_q      <= '0;
      state_q   <= SEARCH;
      run_q     <= '0;
      win_q     <= '0;
      wait_q    <= '0;
      loss_q    <= '0;
      bitslip_q <= 1'b0;
      err_q     <= 1'b0;
      de_q      <= 1'b0;
      ctrl_q    <= 2'b00;
      data_q    <= 8'h00;
    end else begin
      s1_q      <= dec_w;
      state_q   <= state_d;
      run_q     <= run_d;
      win_q     <= win_d;
      wait_q    <= wait_d;
      loss_q    <= loss_d;
      bitslip_q <= (state_q != SLIP) && (state_d == SLIP);
      err_q     <= (state_q == LOCKED) && (state_d == SEARCH);
      if (state_d != LOCKED) begin
        de_q   <= 1'b0;
        ctrl_q <= 2'b00;
        data_q <= 8'h00;
      end else if (s1_q.is_ctrl) begin
        de_q   <= 1'b0;
        ctrl_q <= s1_q.ctrl;
        data_q <= 8'h00;
      end else begin
        de_q   <= 1'b1;
        data_q <= s1_q.data;
      end
    end
  end

  assign O_bitslip = bitslip_q;
  assign O_locked  = (state_q == LOCKED);
  assign O_de      = de_q;
  assign O_ctrl    = ctrl_q;
  assign O_data    = data_q;
  assign O_err     = err_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder: aligned/misaligned streams through a bitslip
// deserializer model, decode and control vectors, loss of lock and async reset.
module tb_tmds_rx_decoder;

  localparam int CTRL_RUN   = 8;
  localparam int SEARCH_WIN = 2048;
  localparam int SLIP_WAIT  = 16;
  localparam int LOSS_WIN   = 4096;
  localparam int LINE       = 1650;
  localparam int BLANK      = 370;

  logic       clk = 1'b0;
  logic       I_rst_n = 1'b1;
  logic [9:0] I_raw = 10'h000;
  logic       O_bitslip, O_locked, O_de, O_err;
  logic [1:0] O_ctrl;
  logic [7:0] O_data;

  always #5 clk = ~clk;

  tmds_rx_decoder #(
    .CTRL_RUN   (CTRL_RUN),
    .SEARCH_WIN (SEARCH_WIN),
    .SLIP_WAIT  (SLIP_WAIT),
    .LOSS_WIN   (LOSS_WIN)
  ) dut (
    .I_pxl_clk (clk),
    .I_rst_n   (I_rst_n),
    .I_raw     (I_raw),
    .O_bitslip (O_bitslip),
    .O_locked  (O_locked),
    .O_de      (O_de),
    .O_ctrl    (O_ctrl),
    .O_data    (O_data),
    .O_err     (O_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [9:0] w);
    @(negedge clk);
    I_raw = w;
  endtask

  // Serial stream model: 370 tokens + 1280 data words per line, bit offset
  // advanced by one on every bitslip pulse seen.
  int         slip_off;
  int         line_pos;
  logic [9:0] prev_w;

  task automatic stream_step();
    logic [9:0]  cur;
    logic [19:0] cat;
    @(negedge clk);
    if (O_bitslip) slip_off = (slip_off + 1) % 10;
    cur      = (line_pos < BLANK) ? 10'h354 : 10'h100;
    line_pos = (line_pos + 1) % LINE;
    cat      = {cur, prev_w} >> slip_off;
    I_raw    = cat[9:0];
    prev_w   = cur;
  endtask

  logic [9:0] tv_raw  [8] = '{10'h100, 10'h1FF, 10'h2FF, 10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h100};
  logic       tv_de   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] tv_ctrl [8] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  logic [7:0] tv_data [8] = '{8'h00, 8'h01, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    int lock_at, nslip, err_at, nerr, slip_at;
    int pulses[$];

    // reset state
    #2 I_rst_n = 1'b0;
    I_raw = 10'h354;
    repeat (3) @(negedge clk);
    chk("rst_locked",  32'(O_locked),  0);
    chk("rst_de",      32'(O_de),      0);
    chk("rst_ctrl",    32'(O_ctrl),    0);
    chk("rst_data",    32'(O_data),    0);
    chk("rst_bitslip", 32'(O_bitslip), 0);
    chk("rst_err",     32'(O_err),     0);

    // aligned stream: tokens land on steps 1..370, 8th token at step 8
    slip_off = 0; line_pos = 0; prev_w = 10'h100;
    stream_step();
    I_rst_n = 1'b1;
    lock_at = 0; nslip = 0;
    for (int k = 1; k <= 2 * LINE; k++) begin
      stream_step();
      if (O_bitslip) nslip++;
      if (O_locked && lock_at == 0) lock_at = k;
      if (k == 1000) begin
        chk("aln_de",   32'(O_de),   1);
        chk("aln_data", 32'(O_data), 32'h00);
      end
    end
    chk("aln_lock_step", lock_at, 10);
    chk("aln_no_slip",   nslip,   0);
    chk("aln_locked",    32'(O_locked), 1);

    // decode / control vectors, outputs 2 clocks after input
    repeat (10) step(10'h0AB);
    for (int i = 0; i < 10; i++) begin
      step((i < 8) ? tv_raw[i] : 10'h100);
      if (i >= 2) begin
        chk($sformatf("vec%0d_de", i - 2),   32'(O_de),   32'(tv_de[i-2]));
        chk($sformatf("vec%0d_ctrl", i - 2), 32'(O_ctrl), 32'(tv_ctrl[i-2]));
        chk($sformatf("vec%0d_data", i - 2), 32'(O_data), 32'(tv_data[i-2]));
      end
    end

    // loss of lock, then hunting resumes
    repeat (10) step(10'h354);
    err_at = 0; nerr = 0; slip_at = 0;
    for (int j = 1; j <= LOSS_WIN + SEARCH_WIN + 3; j++) begin
      step(10'h100);
      if (O_err) begin
        nerr++;
        if (err_at == 0) err_at = j;
      end
      if (O_bitslip && slip_at == 0) slip_at = j;
      if (j == LOSS_WIN + 1) chk("loss_hold", 32'(O_locked), 1);
      if (j == LOSS_WIN + 2) begin
        chk("loss_drop", 32'(O_locked), 0);
        chk("loss_de",   32'(O_de),     0);
      end
    end
    chk("loss_err_step", err_at,  LOSS_WIN + 2);
    chk("loss_err_once", nerr,    1);
    chk("loss_slip",     slip_at, LOSS_WIN + 2 + SEARCH_WIN + 1);
    repeat (20) step(10'h100);

    // interrupted run: 7 tokens, data, 7 tokens -> no lock
    repeat (7) step(10'h354);
    step(10'h100);
    repeat (7) step(10'h354);
    repeat (3) step(10'h100);
    chk("intr_nolock", 32'(O_locked), 0);
    repeat (8) step(10'h0AB);
    step(10'h100);
    chk("intr_lock_early", 32'(O_locked), 0);
    step(10'h100);
    chk("intr_lock", 32'(O_locked), 1);
    chk("intr_ctrl", 32'(O_ctrl),   32'h1);
    chk("intr_de",   32'(O_de),     0);

    // asynchronous reset while locked
    repeat (3) step(10'h1FF);
    chk("pre_rst_data", 32'(O_data), 32'h01);
    #2 I_rst_n = 1'b0;
    #1 chk("rst_mid", 32'({O_locked, O_de, O_ctrl, O_data, O_bitslip, O_err}), 0);

    // misaligned by 3 bits: expect three slips then lock on next blanking
    slip_off = 7; line_pos = 0; prev_w = 10'h354;
    stream_step();
    I_rst_n = 1'b1;
    lock_at = 0;
    for (int k = 1; k <= 12000; k++) begin
      stream_step();
      if (O_bitslip) pulses.push_back(k);
      if (O_locked) begin
        lock_at = k;
        break;
      end
    end
    chk("mis_pulses", pulses.size(), 3);
    if (pulses.size() >= 3) begin
      chk("mis_first",  pulses[0], SEARCH_WIN + 1);
      chk("mis_gap1",   pulses[1] - pulses[0], SEARCH_WIN + SLIP_WAIT + 1);
      chk("mis_gap2",   pulses[2] - pulses[1], SEARCH_WIN + SLIP_WAIT + 1);
      chk("mis_lock_after", 32'(lock_at > pulses[2] &&
                                 lock_at - pulses[2] <= LINE + SLIP_WAIT + CTRL_RUN + 4), 1);
    end
    chk("mis_locked", 32'(O_locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
